// File: rtl/status_flags_unit.sv
// Processor status register (Z/N/C/V) with a LIFO flag-save stack and branch-condition evaluator.
// Define FLAGS_PARITY_EN to add the P (even-parity) flag, saved and restored along with the rest.
module status_flags_unit #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned STACK_DEPTH = 4,
  localparam int unsigned CNT_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  input  logic [3:0]        flag_we,
  input  logic              flag_push,
  input  logic              flag_pop,
  input  logic              err_clr,
  input  logic [3:0]        cond_code,
  output logic [4:0]        flags,
  output logic              cond_true,
  output logic [CNT_W-1:0]  stk_count,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              stk_err
);

`ifdef FLAGS_PARITY_EN
  localparam int unsigned FLAG_W = 5;
`else
  localparam int unsigned FLAG_W = 4;
`endif
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(STACK_DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  logic [FLAG_W-1:0] flags_q, flags_d, alu_flags, top_data;
  logic [FLAG_W-1:0] stack_q [STACK_DEPTH];
  logic [FLAG_W-1:0] stack_d [STACK_DEPTH];
  logic [CNT_W-1:0]  count_q, count_d, top_idx, wr_idx;
  logic              err_q, err_d;
  logic              full, empty;
  logic              do_swap, do_push, do_pop, new_err, stack_we;
  logic              z, n, c, v, p;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign top_idx = count_q - ONE_CNT;

  // Candidate flags from the ALU; flags whose enable is low hold their value.
  always_comb begin
    alu_flags = flags_q;
    if (flag_we[0]) alu_flags[0] = (alu_result == '0);
    if (flag_we[1]) alu_flags[1] = alu_result[DATA_W-1];
    if (flag_we[2]) alu_flags[2] = alu_carry;
    if (flag_we[3]) alu_flags[3] = alu_ovf;
`ifdef FLAGS_PARITY_EN
    if (flag_we[0]) alu_flags[4] = ~^alu_result;
`endif
  end

  always_comb begin
    top_data = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (CNT_W'(i) == top_idx) top_data = stack_q[i];
    end
  end

  // Push+pop on an empty stack degrades to a plain push (never an error).
  always_comb begin
    do_swap = flag_push & flag_pop & ~empty;
    do_push = flag_push & ~do_swap & ~full;
    do_pop  = flag_pop & ~flag_push & ~empty;
    new_err = (flag_push & ~do_swap & full) | (flag_pop & ~flag_push & empty);
  end

  always_comb begin
    flags_d  = alu_flags;
    count_d  = count_q;
    stack_we = 1'b0;
    wr_idx   = count_q;
    if (do_swap) begin
      flags_d  = top_data;
      stack_we = 1'b1;
      wr_idx   = top_idx;
    end else if (do_pop) begin
      flags_d = top_data;
      count_d = count_q - ONE_CNT;
    end else if (do_push) begin
      stack_we = 1'b1;
      count_d  = count_q + ONE_CNT;
    end

    for (int i = 0; i < STACK_DEPTH; i++) begin
      stack_d[i] = stack_q[i];
      if (stack_we && (CNT_W'(i) == wr_idx)) stack_d[i] = flags_q;
    end

    // A fresh error beats a simultaneous clear.
    err_d = err_q;
    if (new_err) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
      err_q   <= err_d;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

`ifdef FLAGS_PARITY_EN
  assign flags = flags_q;
`else
  assign flags = {1'b0, flags_q};
`endif

  assign stk_count = count_q;
  assign stk_full  = full;
  assign stk_empty = empty;
  assign stk_err   = err_q;

  assign z = flags[0];
  assign n = flags[1];
  assign c = flags[2];
  assign v = flags[3];
  assign p = flags[4];

  always_comb begin
    cond_true = 1'b0;
    case (cond_code)
      4'd0:  cond_true = z;
      4'd1:  cond_true = ~z;
      4'd2:  cond_true = c;
      4'd3:  cond_true = ~c;
      4'd4:  cond_true = n;
      4'd5:  cond_true = ~n;
      4'd6:  cond_true = v;
      4'd7:  cond_true = ~v;
      4'd8:  cond_true = (n == v);
      4'd9:  cond_true = (n != v);
      4'd10: cond_true = ~z & (n == v);
      4'd11: cond_true = z | (n != v);
      4'd12: cond_true = c & ~z;
      4'd13: cond_true = ~c | z;
      4'd14: cond_true = 1'b1;
      4'd15: cond_true = p;  // constant 0 when the parity flag is not built
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_status_flags_unit.sv
// Scoreboard bench for status_flags_unit: directed scenarios plus randomized traffic
// checked against a queue-based reference model; honours FLAGS_PARITY_EN.
module tb_status_flags_unit;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned STACK_DEPTH = 4;
  localparam int unsigned CNT_W       = $clog2(STACK_DEPTH + 1);

  typedef struct packed {
    logic [4:0]       flags;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             err;
    logic             cond;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry, alu_ovf;
  logic [3:0]        flag_we;
  logic              flag_push, flag_pop, err_clr;
  logic [3:0]        cond_code;
  logic [4:0]        flags;
  logic              cond_true;
  logic [CNT_W-1:0]  stk_count;
  logic              stk_full, stk_empty, stk_err;

  status_flags_unit #(.DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_ovf    (alu_ovf),
    .flag_we    (flag_we),
    .flag_push  (flag_push),
    .flag_pop   (flag_pop),
    .err_clr    (err_clr),
    .cond_code  (cond_code),
    .flags      (flags),
    .cond_true  (cond_true),
    .stk_count  (stk_count),
    .stk_full   (stk_full),
    .stk_empty  (stk_empty),
    .stk_err    (stk_err)
  );

  always #5 clk = ~clk;

  // Reference model state: flags as {P,V,C,N,Z}, stack as a plain LIFO queue.
  logic [4:0] m_flags;
  logic [4:0] m_stack[$];
  logic       m_err;
  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic eval_cond(input logic [4:0] f, input logic [3:0] cc);
    logic zf, nf, cf, vf;
    zf = f[0]; nf = f[1]; cf = f[2]; vf = f[3];
    case (cc)
      4'd0:  return zf;
      4'd1:  return !zf;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return nf;
      4'd5:  return !nf;
      4'd6:  return vf;
      4'd7:  return !vf;
      4'd8:  return nf == vf;
      4'd9:  return nf != vf;
      4'd10: return !zf && (nf == vf);
      4'd11: return zf || (nf != vf);
      4'd12: return cf && !zf;
      4'd13: return !cf || zf;
      4'd14: return 1'b1;
`ifdef FLAGS_PARITY_EN
      default: return f[4];
`else
      default: return 1'b0;
`endif
    endcase
  endfunction

  // Monitor: compares every registered response against the next scoreboard entry.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin : mon_blk
      exp_t e;
      e = exp_q.pop_front();
      check("flags",     32'(flags),     32'(e.flags));
      check("stk_count", 32'(stk_count), 32'(e.count));
      check("stk_full",  32'(stk_full),  32'(e.full));
      check("stk_empty", 32'(stk_empty), 32'(e.empty));
      check("stk_err",   32'(stk_err),   32'(e.err));
      check("cond_true", 32'(cond_true), 32'(e.cond));
    end
  end

  // One transaction: drive for a single edge, predict, then drop the strobes again.
  task automatic step(input logic [15:0] res, input logic car, input logic ovf,
                      input logic [3:0] we, input logic psh, input logic pp,
                      input logic clr, input logic [3:0] cc);
    logic [4:0] alu_new, tmp;
    logic       was_empty, was_full, err_new;
    exp_t       e;
    @(negedge clk);
    alu_result = res; alu_carry = car; alu_ovf = ovf; flag_we = we;
    flag_push = psh; flag_pop = pp; err_clr = clr; cond_code = cc;

    alu_new = m_flags;
    if (we[0]) alu_new[0] = (res == 16'h0);
    if (we[1]) alu_new[1] = res[15];
    if (we[2]) alu_new[2] = car;
    if (we[3]) alu_new[3] = ovf;
`ifdef FLAGS_PARITY_EN
    if (we[0]) alu_new[4] = (($countones(res) % 2) == 0);
`endif
    was_empty = (m_stack.size() == 0);
    was_full  = (m_stack.size() == STACK_DEPTH);
    err_new   = 1'b0;
    if (psh && pp && !was_empty) begin
      tmp = m_stack[m_stack.size() - 1];
      m_stack[m_stack.size() - 1] = m_flags;
      m_flags = tmp;
    end else if (pp && !psh) begin
      if (was_empty) begin
        err_new = 1'b1;
        m_flags = alu_new;
      end else begin
        m_flags = m_stack.pop_back();
      end
    end else if (psh) begin
      if (was_full) err_new = 1'b1;
      else m_stack.push_back(m_flags);
      m_flags = alu_new;
    end else begin
      m_flags = alu_new;
    end
    if (err_new) m_err = 1'b1;
    else if (clr) m_err = 1'b0;

    e.flags = m_flags;
    e.count = CNT_W'(m_stack.size());
    e.full  = (m_stack.size() == STACK_DEPTH);
    e.empty = (m_stack.size() == 0);
    e.err   = m_err;
    e.cond  = eval_cond(m_flags, cc);
    exp_q.push_back(e);

    @(posedge clk);
    #2;
    flag_we = 4'h0; flag_push = 1'b0; flag_pop = 1'b0; err_clr = 1'b0;
  endtask

  // Async reset asserted and released between clock edges; outputs must clear at once.
  task automatic reset_mid();
    @(negedge clk);
    #1;
    flag_we = 4'h0; flag_push = 1'b0; flag_pop = 1'b0; err_clr = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_count", 32'(stk_count), 32'h0);
    check("rst_empty", 32'(stk_empty), 32'h1);
    check("rst_full",  32'(stk_full), 32'h0);
    check("rst_err",   32'(stk_err), 32'h0);
    #1;
    reset = 1'b0;
    m_flags = 5'h0;
    m_stack.delete();
    m_err = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    alu_result = '0; alu_carry = 1'b0; alu_ovf = 1'b0; flag_we = 4'h0;
    flag_push = 1'b0; flag_pop = 1'b0; err_clr = 1'b0; cond_code = 4'h0;
    m_flags = 5'h0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("init_flags", 32'(flags), 32'h0);
    check("init_empty", 32'(stk_empty), 32'h1);
    @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of activity: count=2, stk_err=1.
    step(16'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0);
    step(16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    step(16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    check("pre_rst_count", 32'(stk_count), 32'd2);
    check("pre_rst_err", 32'(stk_err), 32'd1);
    reset_mid();

    // Negative result with carry and overflow.
    step(16'h8000, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'd9);
    check("t2_flags", 32'(flags[3:0]), 32'hE);
    check("t2_lt", 32'(cond_true), 32'd0);
    step(16'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd8);
    check("t2_ge", 32'(cond_true), 32'd1);
    step(16'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd12);
    check("t2_hi", 32'(cond_true), 32'd1);

    // Save, clobber, restore.
    step(16'h0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'd0);
    check("t3_zero", 32'(flags[3:0]), 32'h1);
    step(16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0);
    step(16'h1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'd0);
    check("t3_clobber", 32'(flags[3:0]), 32'h0);
    step(16'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'd0);
    check("t3_restore", 32'(flags[3:0]), 32'h1);
    check("t3_count", 32'(stk_count), 32'd0);

    // Overflow and underflow of the stack.
    for (int i = 0; i < 5; i++) step(16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0);
    check("t4_count", 32'(stk_count), 32'd4);
    check("t4_full", 32'(stk_full), 32'd1);
    check("t4_err", 32'(stk_err), 32'd1);
    step(16'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'd0);
    check("t4_clr", 32'(stk_err), 32'd0);
    for (int i = 0; i < 4; i++) step(16'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'd0);
    step(16'h8000, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 4'd0);
    check("t4_underflow_err", 32'(stk_err), 32'd1);
    check("t4_underflow_flags", 32'(flags[3:0]), 32'h2);

    // Swap via simultaneous push and pop.
    step(16'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'd0);
    step(16'h8000, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'd0);
    step(16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0);
    step(16'h1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'd0);
    check("t5_pre_flags", 32'(flags[3:0]), 32'h8);
    step(16'h0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 4'd0);
    check("t5_swap_flags", 32'(flags[3:0]), 32'h2);
    check("t5_swap_count", 32'(stk_count), 32'd1);
    step(16'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'd0);
    check("t5_old_top", 32'(flags[3:0]), 32'h8);

    // Parity flag.
    step(16'h0003, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 4'd15);
`ifdef FLAGS_PARITY_EN
    check("t6_p_even", 32'(flags[4]), 32'd1);
    check("t6_cond15", 32'(cond_true), 32'd1);
    step(16'h0007, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 4'd15);
    check("t6_p_odd", 32'(flags[4]), 32'd0);
`else
    check("t6_p_tied", 32'(flags[4]), 32'd0);
    check("t6_cond15", 32'(cond_true), 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] r;
      r = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      if (i == 300) reset_mid();
      step(r, 1'($urandom), 1'($urandom), 4'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0), 4'($urandom));
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
